muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Multi-cycle integer multiply/divide execution unit for the RV32M extension; successor to the single-cycle ALU decode path.
- Decodes func3 directly and runs iterative shift-add multiply or restoring divide over WIDTH cycles.
- Uses a start/busy/done handshake, so the core stalls its execute stage while busy is high.
- Sits beside the main ALU in execute. Its result is muxed into writeback when done is high.

Parameters:
- WIDTH, 32, operand and result width in bits; must be even and >= 4.
- CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when ready state (IDLE or DONE)
- func3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- op_a  input  WIDTH  rs1 operand (dividend / multiplicand)
- op_b  input  WIDTH  rs2 operand (divisor / multiplier)
- flush  input  1  abort in-flight operation (pipeline flush)
- busy  output  1  high while operation in progress
- done  output  1  one-cycle pulse, result valid
- result  output  WIDTH  registered result, held until next accepted start

Behaviour:
Reset and states:
- Reset (rst_n low, asynchronous): state=IDLE, busy=0, done=0, result=0, counter=0, internal regs=0.
- States:
  - IDLE: waiting for start.
  - CALC: one iteration per cycle.
  - FIX: sign correction and high/low select.
  - DONE: done=1 for exactly one cycle.

Accept and operand capture:
- An operation is accepted on the clock edge where start=1 and state is IDLE or DONE. Start in CALC/FIX is ignored, no queueing.
- On accept, the unit latches func3 and the sign flags, and converts operands to magnitudes per op:
  - Signed-signed: MULH, DIV, REM.
  - Signed-unsigned: MULHSU.
  - Unsigned: others.
- MUL is sign-agnostic for the low half.
- It then enters CALC with counter=0, and busy=1 from the next cycle.

CALC:
- Multiply: shift-add over a 2*WIDTH product register; one multiplier bit per cycle.
- Divide: restoring divide; one quotient bit per cycle.
- After WIDTH iterations (counter==WIDTH-1), go to FIX.

FIX:
- Negate the product/quotient/remainder per sign rules: quotient sign = sa^sb; remainder sign = dividend sign.
- Select the result:
  - MUL = low WIDTH bits.
  - MULH/MULHSU/MULHU = high WIDTH bits.
  - DIV/DIVU = quotient.
  - REM/REMU = remainder.
- Register into result, then go to DONE.

DONE:
- done=1, busy=0.
- Next state is IDLE, or CALC if a new start is accepted.

Latency:
- Normal ops: start edge -> done high after WIDTH+2 cycles (WIDTH CALC + FIX + DONE entry). WIDTH=32 gives done on cycle 34.

Special cases, detected at accept, skip CALC and go straight to FIX (done after 2 cycles):
- Divide by zero: DIV/DIVU quotient = all ones; REM/REMU = op_a.
- Signed overflow (DIV/REM with op_a = 1<<(WIDTH-1), op_b = all ones): DIV = op_a; REM = 0.

Flush:
- flush=1 on any edge returns to IDLE, busy=0, done=0. result is not updated. flush has priority over start on the same edge.
- Reset mid-operation: immediate return to reset values. No partial result is visible.

Optional Feature:
MULDIV_FAST_MUL_EN:
- Defined: multiply ops (func3[2]=0) compute the full product with one combinational signed multiplier of WIDTH+1 bits at accept, then go straight to FIX. Multiply latency is 2 cycles; divide is unchanged.
- Undefined: all multiplies are iterative, WIDTH+2 cycles. No multiplier primitive is inferred.
- Results are bit-identical in both builds.

Test Plan:
- Reset: assert rst_n=0 mid-CALC -> busy=0, done=0, result=0 immediately; IDLE after release.
- MUL 7 x -3 (0x00000007, 0xFFFFFFFD) -> done at cycle 34, result=0xFFFFFFEB. MULH same operands -> 0xFFFFFFFF. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
- DIV -7/2 -> 0xFFFFFFFD. REM -7/2 -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIV by zero (op_a=5, op_b=0) -> done at cycle 2, result=0xFFFFFFFF; REMU -> 5. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0.
- Handshake: start held high during busy -> ignored. Back-to-back start in DONE cycle -> accepted, next done 34 cycles later. flush at cycle 10 -> no done pulse, result keeps previous value.
- With MULDIV_FAST_MUL_EN: MULHSU 0xFFFFFFFF x 0x00000002 -> done at cycle 2, result=0xFFFFFFFF; matches iterative build.

Source files
------------

// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M multiply/divide unit: shift-add multiply, restoring divide, start/busy/done handshake.
// Optional MULDIV_FAST_MUL_EN: multiplies use one combinational signed multiplier and skip the iterations.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       func3,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t             state_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [2:0]         func3_r;
  logic               neg_q_r, neg_r_r;
  logic [2*WIDTH-1:0] acc_r;
  logic [WIDTH-1:0]   opd_r;
  logic               busy_r, done_r;
  logic [WIDTH-1:0]   result_r;

  logic               a_signed_s, b_signed_s, sa_s, sb_s;
  logic [WIDTH-1:0]   mag_a_s, mag_b_s;
  logic               is_div_s, div_zero_s, div_ovf_s, skip_calc_s;
  logic               neg_q_load_s, neg_r_load_s;
  logic [2*WIDTH-1:0] acc_load_s;
  logic [WIDTH:0]     mul_sum_s, div_tmp_s, div_diff_s;
  logic [2*WIDTH-1:0] acc_step_s, prod_s;
  logic [WIDTH-1:0]   quo_s, rem_s, fix_s;

`ifdef MULDIV_FAST_MUL_EN
  // Sign-extended (WIDTH+1)-bit operands; only the low 2*WIDTH product bits are meaningful.
  logic signed [2*WIDTH-1:0] fa_s, fb_s, fprod_s;
  assign fa_s    = {{WIDTH{a_signed_s & op_a[WIDTH-1]}}, op_a};
  assign fb_s    = {{WIDTH{b_signed_s & op_b[WIDTH-1]}}, op_b};
  assign fprod_s = fa_s * fb_s;
`endif

  // Operand decode at accept: signedness, magnitudes, special-case detection and register load values.
  always_comb begin
    a_signed_s = 1'b0;
    b_signed_s = 1'b0;
    case (func3)
      3'b001, 3'b100, 3'b110: begin
        a_signed_s = 1'b1;
        b_signed_s = 1'b1;
      end
      3'b010:  a_signed_s = 1'b1;
      default: a_signed_s = 1'b0;
    endcase
    sa_s       = a_signed_s & op_a[WIDTH-1];
    sb_s       = b_signed_s & op_b[WIDTH-1];
    mag_a_s    = sa_s ? (ZERO - op_a) : op_a;
    mag_b_s    = sb_s ? (ZERO - op_b) : op_b;
    is_div_s   = func3[2];
    div_zero_s = is_div_s && (op_b == ZERO);
    div_ovf_s  = is_div_s && !func3[0] && (op_a == SMIN) && (op_b == ONES);
    neg_q_load_s = 1'b0;
    neg_r_load_s = 1'b0;
    skip_calc_s  = 1'b1;
    // Special cases preload the final unsigned answer so FIX applies no sign correction.
    if (div_zero_s) begin
      acc_load_s = {op_a, ONES};
    end else if (div_ovf_s) begin
      acc_load_s = {ZERO, op_a};
    end else if (is_div_s) begin
      acc_load_s   = {ZERO, mag_a_s};
      neg_q_load_s = sa_s ^ sb_s;
      neg_r_load_s = sa_s;
      skip_calc_s  = 1'b0;
`ifdef MULDIV_FAST_MUL_EN
    end else begin
      acc_load_s = fprod_s;
`else
    end else begin
      acc_load_s   = {ZERO, mag_b_s};
      neg_q_load_s = sa_s ^ sb_s;
      skip_calc_s  = 1'b0;
`endif
    end
  end

  // One iteration step: shift-add for multiply, restoring subtract for divide.
  always_comb begin
    mul_sum_s  = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + (acc_r[0] ? {1'b0, opd_r} : {(WIDTH+1){1'b0}});
    div_tmp_s  = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
    div_diff_s = div_tmp_s - {1'b0, opd_r};
    if (func3_r[2]) begin
      if (!div_diff_s[WIDTH]) begin
        acc_step_s = {div_diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
      end else begin
        acc_step_s = {div_tmp_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_step_s = {mul_sum_s, acc_r[WIDTH-1:1]};
    end
  end

  // Sign correction and result select.
  always_comb begin
    prod_s = neg_q_r ? ({(2*WIDTH){1'b0}} - acc_r) : acc_r;
    quo_s  = neg_q_r ? (ZERO - acc_r[WIDTH-1:0]) : acc_r[WIDTH-1:0];
    rem_s  = neg_r_r ? (ZERO - acc_r[2*WIDTH-1:WIDTH]) : acc_r[2*WIDTH-1:WIDTH];
    case (func3_r)
      3'b000:                 fix_s = prod_s[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: fix_s = prod_s[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:         fix_s = quo_s;
      default:                fix_s = rem_s;
    endcase
  end

  // Control FSM with registered handshake outputs and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= S_IDLE;
      cnt_r    <= {CNT_W{1'b0}};
      func3_r  <= 3'b000;
      neg_q_r  <= 1'b0;
      neg_r_r  <= 1'b0;
      acc_r    <= {(2*WIDTH){1'b0}};
      opd_r    <= ZERO;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      result_r <= ZERO;
    end else if (flush) begin
      state_r <= S_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE, S_DONE: begin
          done_r <= 1'b0;
          if (start) begin
            func3_r <= func3;
            neg_q_r <= neg_q_load_s;
            neg_r_r <= neg_r_load_s;
            acc_r   <= acc_load_s;
            opd_r   <= is_div_s ? mag_b_s : mag_a_s;
            cnt_r   <= {CNT_W{1'b0}};
            busy_r  <= 1'b1;
            state_r <= skip_calc_s ? S_FIX : S_CALC;
          end else begin
            busy_r  <= 1'b0;
            state_r <= S_IDLE;
          end
        end
        S_CALC: begin
          acc_r <= acc_step_s;
          cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          if (cnt_r == CNT_W'(WIDTH-1)) begin
            state_r <= S_FIX;
          end else begin
            state_r <= S_CALC;
          end
        end
        S_FIX: begin
          result_r <= fix_s;
          busy_r   <= 1'b0;
          done_r   <= 1'b1;
          state_r  <= S_DONE;
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign busy   = busy_r;
  assign done   = done_r;
  assign result = result_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected result/latency queued at start, checked when done pulses.
module tb_muldiv_unit;
  localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [2:0]    func3 = 3'b000;
  logic [W-1:0]  op_a = 32'd0;
  logic [W-1:0]  op_b = 32'd0;
  logic          flush = 1'b0;
  logic          busy, done;
  logic [W-1:0]  result;

  typedef struct { logic [31:0] res; int lat; } exp_t;
  exp_t sb_q[$];
  int n_vec = 0;
  int n_err = 0;
  int lat_cnt = 0;
  logic [31:0] last_res = 32'd0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .func3(func3), .op_a(op_a),
    .op_b(op_b), .flush(flush), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    logic signed [63:0] pa, pb;
    logic [63:0] p;
    logic [31:0] r;
    sa = a; sb = b; pa = sa; pb = sb;
    r = 32'd0;
    case (f)
      3'd0: begin p = {32'd0, a} * {32'd0, b}; r = p[31:0]; end
      3'd1: begin p = pa * pb; r = p[63:32]; end
      3'd2: begin p = pa * $signed({32'd0, b}); r = p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; r = p[63:32]; end
      3'd4: begin
        if (b == 32'd0) r = 32'hFFFFFFFF;
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = a;
        else r = 32'(sa / sb);
      end
      3'd5: begin if (b == 32'd0) r = 32'hFFFFFFFF; else r = a / b; end
      3'd6: begin
        if (b == 32'd0) r = a;
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'd0;
        else r = 32'(sa % sb);
      end
      default: begin if (b == 32'd0) r = a; else r = a % b; end
    endcase
    return r;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
    lat_cnt++;
  endtask

  task automatic drive_start(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    exp_t e;
    bit special;
    special = f[2] && ((b == 32'd0) || (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF));
    e.res = exp;
    e.lat = (special || (!f[2] && FAST)) ? 2 : W + 2;
    sb_q.push_back(e);
    func3 = f; op_a = a; op_b = b; start = 1'b1;
    lat_cnt = 0;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done();
    exp_t e;
    while (!done && lat_cnt < 200) tick();
    if (!done) begin
      check_eq("done_timeout", 64'd0, 64'd1);
      if (sb_q.size() > 0) e = sb_q.pop_front();
    end else if (sb_q.size() == 0) begin
      check_eq("unexpected_done", 64'd1, 64'd0);
    end else begin
      e = sb_q.pop_front();
      check_eq("result", 64'(result), 64'(e.res));
      check_eq("latency", 64'(lat_cnt), 64'(e.lat));
      check_eq("busy_in_done", 64'(busy), 64'd0);
      last_res = e.res;
    end
  endtask

  task automatic run(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    drive_start(f, a, b, exp);
    wait_done();
  endtask

  initial begin
    int done_seen;
    exp_t dropped;
    logic [2:0] rf;
    logic [31:0] ra, rb;

    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_busy", 64'(busy), 64'd0);
    check_eq("reset_done", 64'(done), 64'd0);
    check_eq("reset_result", 64'(result), 64'd0);
    rst_n = 1'b1;
    tick();

    run(3'd0, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB);
    run(3'd1, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF);
    run(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
    run(3'd2, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF);
    run(3'd4, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD);
    run(3'd6, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF);
    run(3'd5, 32'd100, 32'd7, 32'd14);
    run(3'd7, 32'd100, 32'd7, 32'd2);
    run(3'd4, 32'd5, 32'd0, 32'hFFFFFFFF);
    run(3'd7, 32'd5, 32'd0, 32'd5);
    run(3'd6, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9);
    run(3'd5, 32'd9, 32'd0, 32'hFFFFFFFF);
    run(3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
    run(3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000);

    for (int i = 0; i < 16; i++) begin
      rf = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = (i % 4 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      run(rf, ra, rb, ref_op(rf, ra, rb));
    end

    // Back-to-back: second start lands in the DONE cycle
    drive_start(3'd5, 32'd100, 32'd7, 32'd14);
    wait_done();
    run(3'd6, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF);

    // start held high while busy must not restart or recapture operands
    drive_start(3'd4, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD);
    func3 = 3'd3; op_a = 32'hFFFFFFFF; op_b = 32'hFFFFFFFF; start = 1'b1;
    repeat (20) tick();
    start = 1'b0;
    wait_done();

    // Flush on cycle 10: no done pulse, result keeps previous value
    drive_start(3'd5, 32'd1000, 32'd3, 32'd333);
    while (lat_cnt < 9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    dropped = sb_q.pop_front();
    check_eq("flush_busy", 64'(busy), 64'd0);
    check_eq("flush_done", 64'(done), 64'd0);
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) done_seen++;
    end
    check_eq("flush_no_done", 64'(done_seen), 64'd0);
    check_eq("flush_result", 64'(result), 64'(last_res));

    // Flush wins over start on the same edge
    func3 = 3'd5; op_a = 32'd50; op_b = 32'd5; start = 1'b1; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0;
    check_eq("flush_vs_start_busy", 64'(busy), 64'd0);
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) done_seen++;
    end
    check_eq("flush_vs_start_done", 64'(done_seen), 64'd0);

    // Asynchronous reset mid-CALC
    drive_start(3'd7, 32'd100, 32'd7, 32'd2);
    while (lat_cnt < 5) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_busy", 64'(busy), 64'd0);
    check_eq("rst_mid_done", 64'(done), 64'd0);
    check_eq("rst_mid_result", 64'(result), 64'd0);
    dropped = sb_q.pop_front();
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("post_rst_busy", 64'(busy), 64'd0);
    run(3'd5, 32'd100, 32'd7, 32'd14);

    check_eq("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
